// File: rtl/serv_seq.sv
// ============================================================================
//  Module   : serv_seq
//  Purpose  : Bit-serial instruction sequencer. It runs fetch, the optional
//             init pass, the optional memory wait, and the run or trap pass.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serv_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             i_rst,
   input  logic             i_ibus_ack,
   input  logic             i_two_stage,
   input  logic             i_mem_op,
   input  logic             i_trap_req,
   input  logic             i_dbus_ack,
   output logic             o_en,
   output logic             o_pc_en,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_cnt_done,
   output logic             o_init,
   output logic             o_trap,
   output logic             o_dbus_cyc
);

   // The counter wraps naturally only when WIDTH fills CNT_W exactly.
   generate
      if (((1 << CNT_W) != WIDTH) || (WIDTH < 4)) begin : g_bad_param
         $error("serv_seq: WIDTH must be a power of two >= 4 and equal 2**CNT_W");
      end
   endgenerate

   localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_INIT  = 3'd1,
      S_MEM   = 3'd2,
      S_RUN   = 3'd3,
      S_TRAP  = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             w_en;
   logic             w_cnt_done;

   assign w_en       = (r_state == S_INIT) || (r_state == S_RUN) || (r_state == S_TRAP);
   assign w_cnt_done = w_en && (r_cnt == c_last_bit);

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_state <= S_FETCH;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         // Free-running wrap keeps every pass starting at bit 0.
         if (w_en) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            r_cnt <= '0;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FETCH: begin
            if (i_ibus_ack) begin
               if (i_trap_req) begin
                  w_state_nxt = S_TRAP;
               end else if (i_two_stage) begin
                  w_state_nxt = S_INIT;
               end else begin
                  w_state_nxt = S_RUN;
               end
            end
         end
         S_INIT: begin
            if (w_cnt_done) begin
               if (i_trap_req) begin
                  w_state_nxt = S_TRAP;
               end else if (i_mem_op) begin
                  w_state_nxt = S_MEM;
               end else begin
                  w_state_nxt = S_RUN;
               end
            end
         end
         S_MEM: begin
            if (i_dbus_ack) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN, S_TRAP: begin
            if (w_cnt_done) begin
               w_state_nxt = S_FETCH;
            end
         end
         default: w_state_nxt = S_FETCH;
      endcase
   end

   // Moore decode only: nothing here looks at an input port.
   assign o_en       = w_en;
   assign o_pc_en    = (r_state == S_RUN) || (r_state == S_TRAP);
   assign o_cnt      = r_cnt;
   assign o_cnt_done = w_cnt_done;
   assign o_init     = (r_state == S_INIT);
   assign o_trap     = (r_state == S_TRAP);
   assign o_dbus_cyc = (r_state == S_MEM);

endmodule

`default_nettype wire

// File: tb/tb_serv_seq.sv
// ============================================================================
//  Module   : tb_serv_seq
//  Purpose  : Directed self-checking bench for serv_seq.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serv_seq;

   localparam int c_width = 32;
   localparam int c_cnt_w = 5;

   logic               clk = 1'b0;
   logic               i_rst;
   logic               i_ibus_ack;
   logic               i_two_stage;
   logic               i_mem_op;
   logic               i_trap_req;
   logic               i_dbus_ack;
   logic               o_en;
   logic               o_pc_en;
   logic [c_cnt_w-1:0] o_cnt;
   logic               o_cnt_done;
   logic               o_init;
   logic               o_trap;
   logic               o_dbus_cyc;

   int n_checks = 0;
   int n_pass   = 0;

   serv_seq #(.WIDTH(c_width), .CNT_W(c_cnt_w)) dut (
      .clk        (clk),
      .i_rst      (i_rst),
      .i_ibus_ack (i_ibus_ack),
      .i_two_stage(i_two_stage),
      .i_mem_op   (i_mem_op),
      .i_trap_req (i_trap_req),
      .i_dbus_ack (i_dbus_ack),
      .o_en       (o_en),
      .o_pc_en    (o_pc_en),
      .o_cnt      (o_cnt),
      .o_cnt_done (o_cnt_done),
      .o_init     (o_init),
      .o_trap     (o_trap),
      .o_dbus_cyc (o_dbus_cyc)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic expect_outs(input string tag, input logic en, input logic pc,
                              input logic init, input logic trap, input logic dbus,
                              input int cnt);
      chk({tag, ".en"},   32'(o_en),       32'(en));
      chk({tag, ".pc"},   32'(o_pc_en),    32'(pc));
      chk({tag, ".init"}, 32'(o_init),     32'(init));
      chk({tag, ".trap"}, 32'(o_trap),     32'(trap));
      chk({tag, ".dbus"}, 32'(o_dbus_cyc), 32'(dbus));
      chk({tag, ".cnt"},  32'(o_cnt),      32'(cnt));
      chk({tag, ".done"}, 32'(o_cnt_done), 32'(en && (cnt == c_width - 1)));
   endtask

   // One full active pass; optionally raise trap_req for the final edge.
   task automatic run_pass(input string tag, input logic pc, input logic init,
                           input logic trap, input logic trap_at_end);
      for (int k = 0; k < c_width; k++) begin
         expect_outs($sformatf("%s[%0d]", tag, k), 1'b1, pc, init, trap, 1'b0, k);
         if (k == c_width - 1 && trap_at_end) i_trap_req = 1'b1;
         tick();
      end
   endtask

   task automatic expect_idle(input string tag);
      expect_outs(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic fetch_ack(input logic two_stage, input logic mem_op, input logic trap);
      i_ibus_ack  = 1'b1;
      i_two_stage = two_stage;
      i_mem_op    = mem_op;
      i_trap_req  = trap;
      tick();
      i_ibus_ack  = 1'b0;
   endtask

   initial begin
      i_rst       = 1'b1;
      i_ibus_ack  = 1'b0;
      i_two_stage = 1'b0;
      i_mem_op    = 1'b0;
      i_trap_req  = 1'b0;
      i_dbus_ack  = 1'b0;
      tick();
      tick();
      expect_idle("reset");
      i_rst = 1'b0;
      tick();
      expect_idle("idle");

      // Single-stage instruction
      fetch_ack(1'b0, 1'b0, 1'b0);
      run_pass("run1", 1'b1, 1'b0, 1'b0, 1'b0);
      expect_idle("run1.end");

      // Two-stage, no memory; spurious dbus ack in INIT, spurious ibus ack in RUN
      fetch_ack(1'b1, 1'b0, 1'b0);
      i_dbus_ack = 1'b1;
      run_pass("init2", 1'b0, 1'b1, 1'b0, 1'b0);
      i_dbus_ack = 1'b0;
      i_ibus_ack = 1'b1;
      run_pass("run2", 1'b1, 1'b0, 1'b0, 1'b0);
      i_ibus_ack = 1'b0;
      expect_idle("run2.end");
      tick();
      expect_idle("run2.noextra");

      // Load/store with dbus ack after 5 MEM cycles
      fetch_ack(1'b1, 1'b1, 1'b0);
      run_pass("init3", 1'b0, 1'b1, 1'b0, 1'b0);
      for (int m = 0; m < 5; m++) begin
         expect_outs($sformatf("mem3[%0d]", m), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
         if (m == 4) i_dbus_ack = 1'b1;
         tick();
      end
      i_dbus_ack = 1'b0;
      run_pass("run3", 1'b1, 1'b0, 1'b0, 1'b0);
      expect_idle("run3.end");

      // Misalign trap at end of init overrides mem_op
      fetch_ack(1'b1, 1'b1, 1'b0);
      run_pass("init4", 1'b0, 1'b1, 1'b0, 1'b1);
      run_pass("trap4", 1'b1, 1'b0, 1'b1, 1'b0);
      i_trap_req = 1'b0;
      expect_idle("trap4.end");

      // Trap at fetch
      fetch_ack(1'b1, 1'b0, 1'b1);
      i_trap_req = 1'b0;
      run_pass("trap5", 1'b1, 1'b0, 1'b1, 1'b0);
      expect_idle("trap5.end");

      // Reset at cnt=17 of RUN
      fetch_ack(1'b0, 1'b0, 1'b0);
      for (int k = 0; k <= 17; k++) begin
         expect_outs($sformatf("run6[%0d]", k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, k);
         if (k == 17) i_rst = 1'b1;
         tick();
      end
      i_rst = 1'b0;
      expect_idle("rst6");
      tick();
      expect_idle("rst6.hold");

      // Reset wins over a simultaneous ack
      i_rst = 1'b1;
      fetch_ack(1'b0, 1'b0, 1'b0);
      i_rst = 1'b0;
      expect_idle("rst7");

      fetch_ack(1'b0, 1'b0, 1'b0);
      run_pass("run8", 1'b1, 1'b0, 1'b0, 1'b0);
      expect_idle("run8.end");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
